// File: rtl/my_mux_pkg.sv
// Shared constants and the rotate-and-pick helper for the N-channel registered mux.
package my_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Upper bound on channel count; the helper works on this fixed width.
  localparam int MAX_N = 16;

  // Returns {found, index}: the first set request scanning ptr, ptr+1, ..., n-1, 0, ..., ptr-1.
  // The loop runs from the far end back so the earliest position in the scan wins.
  function automatic logic [4:0] rr_pick(input logic [MAX_N-1:0] req,
                                         input logic [3:0]       ptr,
                                         input int               n);
    logic [4:0] r;
    int         c;
    r = '0;
    for (int k = MAX_N - 1; k >= 0; k--) begin
      if (k < n) begin
        c = int'(ptr) + k;
        if (c >= n) c = c - n;
        if (req[c[3:0]]) r = {1'b1, c[3:0]};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/my_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr.
module my_rr_arbiter
  import my_mux_pkg::*;
#(
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt_onehot,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [MAX_N-1:0] req_w;
  logic [3:0]       ptr_w;
  logic [4:0]       pick;

  assign req_w      = MAX_N'(req);
  assign ptr_w      = 4'(ptr);
  assign pick       = rr_pick(req_w, ptr_w, N);
  assign gnt_any    = en & pick[4];
  assign gnt_idx    = SEL_W'(pick[3:0]);
  assign gnt_onehot = gnt_any ? (N'(1) << gnt_idx) : '0;

endmodule

// File: rtl/my_mux_n_rr.sv
// N-channel registered mux with valid/ready on every side, fixed or round-robin selection.
module my_mux_n_rr
  import my_mux_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [WIDTH-1:0] out_data_q;
  logic [SEL_W-1:0] out_chan_q;
  logic             out_valid_q;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             load_en;
  logic [N-1:0]     rr_oh, fix_oh;
  logic [SEL_W-1:0] rr_idx, gnt_idx;
  logic             rr_any, fix_ok, xfer;
  logic [WIDTH-1:0] gnt_data;

  // Output register can take a word when empty or being drained this cycle.
  assign load_en = !out_valid_q || out_ready;

  my_rr_arbiter #(.N(N)) u_arb (
    .req       (in_valid),
    .ptr       (rr_ptr_q),
    .en        (load_en),
    .gnt_onehot(rr_oh),
    .gnt_idx   (rr_idx),
    .gnt_any   (rr_any)
  );

  // Fixed mode: sel must name an existing channel that is valid; sel >= N never matches.
  always_comb begin
    fix_ok = 1'b0;
    for (int i = 0; i < N; i++)
      if (sel == SEL_W'(i) && in_valid[i]) fix_ok = 1'b1;
  end

  assign fix_oh   = (load_en && fix_ok) ? (N'(1) << sel) : '0;
  assign gnt_idx  = (mode == MODE_RR) ? rr_idx : sel;
  assign xfer     = rst_n && ((mode == MODE_RR) ? rr_any : (load_en && fix_ok));
  assign in_ready = rst_n ? ((mode == MODE_RR) ? rr_oh : fix_oh) : '0;

  // Select the granted channel's data word.
  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N; i++)
      if (gnt_idx == SEL_W'(i)) gnt_data = in_data[i*WIDTH +: WIDTH];
  end

  // Pointer moves just past the channel that won an RR transfer.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer && mode == MODE_RR)
      rr_ptr_d = (gnt_idx == SEL_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Output register: load on transfer, clear valid on drain, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (xfer) begin
        out_data_q  <= gnt_data;
        out_chan_q  <= gnt_idx;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_my_mux_n_rr.sv
// Bench: an N=4 and an N=3 instance share stimulus; a queue-free reference model
// derived from the grant rules predicts in_ready and the output register each cycle.
module tb_my_mux_n_rr;

  logic        clk = 1'b0;
  logic        rst_n, mode, ordy;
  logic [1:0]  sel;
  logic [63:0] din;
  logic [3:0]  vld;

  logic [3:0]  rdy_a;
  logic [15:0] od_a;
  logic [1:0]  oc_a;
  logic        ov_a;
  logic [2:0]  rdy_b;
  logic [15:0] od_b;
  logic [1:0]  oc_b;
  logic        ov_b;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state per instance (0: N=4, 1: N=3).
  int          m_ov[2], m_oc[2], m_ptr[2];
  logic [15:0] m_od[2];

  always #5 clk = ~clk;

  my_mux_n_rr #(.WIDTH(16), .N(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(din),
    .in_valid(vld), .in_ready(rdy_a), .out_data(od_a), .out_chan(oc_a),
    .out_valid(ov_a), .out_ready(ordy)
  );

  my_mux_n_rr #(.WIDTH(16), .N(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(din[47:0]),
    .in_valid(vld[2:0]), .in_ready(rdy_b), .out_data(od_b), .out_chan(oc_b),
    .out_valid(ov_b), .out_ready(ordy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Which channel the spec says is granted this cycle, or -1.
  function automatic int mgrant(input int d);
    int n;
    n = (d == 0) ? 4 : 3;
    if (!rst_n) return -1;
    if (m_ov[d] != 0 && !ordy) return -1;
    if (!mode) return (int'(sel) < n && vld[sel]) ? int'(sel) : -1;
    for (int k = 0; k < n; k++) begin
      int c;
      c = (m_ptr[d] + k) % n;
      if (vld[c]) return c;
    end
    return -1;
  endfunction

  // One clock: check combinational ready + registered outputs, then advance the model.
  task automatic step();
    int g[2];
    #1;
    for (int d = 0; d < 2; d++) begin
      string p;
      int    er;
      p     = (d == 0) ? "A." : "B.";
      g[d]  = mgrant(d);
      er    = (g[d] >= 0) ? (1 << g[d]) : 0;
      chk({p, "in_ready"},  (d == 0) ? 32'(rdy_a) : 32'(rdy_b), er);
      chk({p, "out_valid"}, (d == 0) ? 32'(ov_a)  : 32'(ov_b),  m_ov[d]);
      chk({p, "out_data"},  (d == 0) ? 32'(od_a)  : 32'(od_b),  32'(m_od[d]));
      chk({p, "out_chan"},  (d == 0) ? 32'(oc_a)  : 32'(oc_b),  m_oc[d]);
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      int n;
      n = (d == 0) ? 4 : 3;
      if (!rst_n) begin
        m_ov[d] = 0; m_od[d] = '0; m_oc[d] = 0; m_ptr[d] = 0;
      end else if (g[d] >= 0) begin
        m_ov[d] = 1;
        m_od[d] = din[g[d]*16 +: 16];
        m_oc[d] = g[d];
        if (mode) m_ptr[d] = (g[d] == n - 1) ? 0 : g[d] + 1;
      end else if (ordy) begin
        m_ov[d] = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_b2_data();
    for (int i = 0; i < 4; i++) din[i*16 +: 16] = 16'h0100 * 16'(i) + 16'h00B2;
  endtask

  initial begin
    int exp_skip[4];
    exp_skip = '{1, 3, 1, 3};
    for (int d = 0; d < 2; d++) begin
      m_ov[d] = 0; m_od[d] = '0; m_oc[d] = 0; m_ptr[d] = 0;
    end

    // Reset with everything valid and the consumer ready.
    rst_n = 1'b0; mode = 1'b1; sel = 2'd0; vld = 4'hF; ordy = 1'b1;
    din = {$urandom, $urandom};
    @(posedge clk); @(negedge clk);
    step();
    chk("rst_in_ready", 32'(rdy_a), 0);

    // RR fairness: full rotation, no bubbles.
    rst_n = 1'b1; set_b2_data();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_seq_chan", 32'(oc_a), k % 4);
      chk("rr_seq_vld",  32'(ov_a), 1);
    end

    // Fixed mode basic.
    mode = 1'b0; sel = 2'd2; vld = 4'b0100; din[47:32] = 16'hCCCC;
    step();
    chk("fix_data", 32'(od_a), 32'hCCCC);
    chk("fix_chan", 32'(oc_a), 2);

    // RR skip over idle channels.
    mode = 1'b1; vld = 4'b1010; set_b2_data();
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_skip_chan", 32'(oc_a), exp_skip[k]);
    end

    // Backpressure: hold 0x02B2 while the consumer stalls.
    vld = 4'hF;
    for (int k = 0; k < 3; k++) step();
    chk("bp_loaded", 32'(od_a), 32'h02B2);
    ordy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_hold_data", 32'(od_a), 32'h02B2);
      chk("bp_hold_rdy",  32'(rdy_a), 0);
    end
    ordy = 1'b1;
    step();
    chk("bp_release_chan", 32'(oc_a), 3);
    chk("bp_release_vld",  32'(ov_a), 1);

    // Out-of-range sel on the 3-channel instance never grants.
    mode = 1'b0; sel = 2'd3;
    for (int k = 0; k < 3; k++) step();
    chk("oor_vld_b", 32'(ov_b), 0);
    chk("oor_rdy_b", 32'(rdy_b), 0);

    // Reset while holding a word discards it.
    mode = 1'b1;
    step();
    chk("pre_rst_vld_b", 32'(ov_b), 1);
    rst_n = 1'b0;
    step();
    chk("mid_rst_vld_b", 32'(ov_b), 0);
    chk("mid_rst_vld_a", 32'(ov_a), 0);
    rst_n = 1'b1;

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      mode  = 1'($urandom);
      sel   = 2'($urandom);
      vld   = 4'($urandom);
      ordy  = ($urandom_range(0, 3) != 0);
      din   = {$urandom, $urandom};
      step();
    end
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
